// File: rtl/cache_fill_fsm.sv
// Block-fill miss handler in front of memory4c: 8 pipelined word reads per miss.
// Define CRITICAL_WORD_FIRST_EN for wrapped word order and a crit_valid output.
module cache_fill_fsm #(
    parameter int ADDR_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    input  logic [15:0]           memory_data,
    input  logic                  memory_data_valid,
    output logic                  fsm_busy,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  write_data_array,
    output logic                  write_tag_array,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [15:0]           fill_data
`ifdef CRITICAL_WORD_FIRST_EN
    ,
    output logic                  crit_valid
`endif
);

    localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
    localparam int OFF_W = IDX_W + 1;
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]      recv_cnt_q, recv_cnt_d;
    logic [IDX_W-1:0]      issue_word, recv_word;
    logic [ADDR_WIDTH-1:0] issue_addr, recv_addr;
    logic [ADDR_WIDTH-1:0] miss_base;

    assign miss_base = {miss_address[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

`ifdef CRITICAL_WORD_FIRST_EN
    logic [IDX_W-1:0] start_q, start_d;
    logic             unused_lo;

    assign unused_lo = miss_address[0];
    // IDX_W-bit sum wraps the word index around the block
    assign issue_word = start_q + issue_cnt_q[IDX_W-1:0];
    assign recv_word  = start_q + recv_cnt_q[IDX_W-1:0];
`else
    logic [OFF_W-1:0] unused_lo;

    assign unused_lo  = miss_address[OFF_W-1:0];
    assign issue_word = issue_cnt_q[IDX_W-1:0];
    assign recv_word  = recv_cnt_q[IDX_W-1:0];
`endif

    assign issue_addr = base_q + ADDR_WIDTH'({issue_word, 1'b0});
    assign recv_addr  = base_q + ADDR_WIDTH'({recv_word, 1'b0});
    assign mem_wr     = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
            start_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
`ifdef CRITICAL_WORD_FIRST_EN
            start_q     <= start_d;
`endif
        end
    end

    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        issue_cnt_d      = issue_cnt_q;
        recv_cnt_d       = recv_cnt_q;
        fsm_busy         = 1'b0;
        mem_en           = 1'b0;
        mem_addr         = '0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        fill_addr        = '0;
        fill_data        = '0;
`ifdef CRITICAL_WORD_FIRST_EN
        start_d          = start_q;
        crit_valid       = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    state_d     = FILL;
                    base_d      = miss_base;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
`ifdef CRITICAL_WORD_FIRST_EN
                    start_d     = miss_address[OFF_W-1:1];
`endif
                end
            end
            FILL: begin
                fsm_busy = 1'b1;
                if (issue_cnt_q < FULL) begin
                    mem_en      = 1'b1;
                    mem_addr    = issue_addr;
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                end
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    fill_addr        = recv_addr;
                    fill_data        = memory_data;
                    recv_cnt_d       = recv_cnt_q + CNT_W'(1);
`ifdef CRITICAL_WORD_FIRST_EN
                    crit_valid       = (recv_cnt_q == '0);
`endif
                    // last word also commits the tag
                    if (recv_cnt_q == LAST) begin
                        write_tag_array = 1'b1;
                        state_d         = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm with a 4-cycle pipelined memory model.
module tb_cache_fill_fsm;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          miss_detected;
    logic [AW-1:0] miss_address;
    logic [15:0]   memory_data;
    logic          memory_data_valid;
    logic          fsm_busy;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic          write_data_array;
    logic          write_tag_array;
    logic [AW-1:0] fill_addr;
    logic [15:0]   fill_data;
    logic          crit;
`ifdef CRITICAL_WORD_FIRST_EN
    logic          crit_valid;
    assign crit = crit_valid;
`else
    assign crit = 1'b0;
`endif

    cache_fill_fsm #(
        .ADDR_WIDTH     (AW),
        .WORDS_PER_BLOCK(8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .memory_data      (memory_data),
        .memory_data_valid(memory_data_valid),
        .fsm_busy         (fsm_busy),
        .mem_en           (mem_en),
        .mem_wr           (mem_wr),
        .mem_addr         (mem_addr),
        .write_data_array (write_data_array),
        .write_tag_array  (write_tag_array),
        .fill_addr        (fill_addr),
        .fill_data        (fill_data)
`ifdef CRITICAL_WORD_FIRST_EN
        ,
        .crit_valid       (crit_valid)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // memory contents: block 0x1230 holds 0xA000+k, elsewhere addr^0x3C3C
    function automatic logic [15:0] mem_val(input logic [15:0] a);
        if (a[15:4] == 12'h123)
            return 16'hA000 + {13'b0, a[3:1]};
        return a ^ 16'h3C3C;
    endfunction

    // read pipeline is not reset, so it flushes stray valids after a reset
    logic [3:0]    pv = '0;
    logic [AW-1:0] pa [4] = '{default: '0};
    always @(posedge clk) begin
        pv    <= {pv[2:0], mem_en & ~mem_wr};
        pa[0] <= mem_addr;
        pa[1] <= pa[0];
        pa[2] <= pa[1];
        pa[3] <= pa[2];
    end
    assign memory_data_valid = pv[3];
    assign memory_data       = mem_val(pa[3]);

    typedef struct {
        int          c;
        logic [15:0] a;
    } iss_t;
    typedef struct {
        int          c;
        logic [15:0] a;
        logic [15:0] d;
        logic        tag;
        logic        crit;
    } wr_t;

    iss_t iss_q[$];
    wr_t  wr_q[$];
    bit   exp_busy [0:4095];
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) step;
        @(negedge clk);
        #1;
    endtask

    task automatic outs_zero(input string nm);
        logic [63:0] v;
        v = {11'b0, fsm_busy, mem_en, mem_wr, write_data_array,
             write_tag_array, mem_addr, fill_addr, fill_data};
        v[63] = crit;
        chk(nm, v, 64'h0);
    endtask

    task automatic expect_fill(input logic [15:0] a, input int e);
        logic [15:0] base, ad;
        logic [2:0]  st, w;
        base = {a[15:4], 4'h0};
`ifdef CRITICAL_WORD_FIRST_EN
        st = a[3:1];
`else
        st = 3'd0;
`endif
        for (int i = 0; i < 8; i++) begin
            w  = st + 3'(i);
            ad = base + {12'b0, w, 1'b0};
            iss_q.push_back('{e + i, ad});
            wr_q.push_back('{e + 4 + i, ad, mem_val(ad), i == 7, i == 0});
        end
        for (int i = 0; i < 12; i++) exp_busy[e + i] = 1'b1;
    endtask

    task automatic start_fill(input logic [15:0] a, input bit hold,
                              output int e);
        step;
        miss_address  = a;
        miss_detected = 1'b1;
        e = cyc + 1;
        expect_fill(a, e);
        step;
        if (!hold) miss_detected = 1'b0;
    endtask

    task automatic wait_idle;
        for (int i = 0; i < 60; i++) begin
            if (!fsm_busy && wr_q.size() == 0 && iss_q.size() == 0)
                return;
            step;
        end
        nvec++;
        nerr++;
        $display("FAIL idle_timeout @cyc %0d: busy=%0b wq=%0d iq=%0d",
                 cyc, fsm_busy, wr_q.size(), iss_q.size());
    endtask

    initial begin : monitor
        iss_t ie;
        wr_t  we;
        forever begin
            @(negedge clk);
            chk("mem_wr", {63'b0, mem_wr}, 64'h0);
            if (rst_n)
                chk("busy", {63'b0, fsm_busy},
                    {63'b0, (cyc < 4096) ? exp_busy[cyc] : 1'b0});
            if (mem_en) begin
                if (iss_q.size() == 0) begin
                    chk("issue_unexp", {48'b0, mem_addr}, 64'hFFFF_FFFF);
                end else begin
                    ie = iss_q.pop_front();
                    chk("issue", {cyc, 16'h0, mem_addr},
                        {ie.c, 16'h0, ie.a});
                end
            end else begin
                chk("addr_idle", {48'b0, mem_addr}, 64'h0);
            end
            if (write_data_array) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexp", {48'b0, fill_addr}, 64'hFFFF_FFFF);
                end else begin
                    we = wr_q.pop_front();
                    chk("wr", {cyc, fill_addr, fill_data},
                        {we.c, we.a, we.d});
`ifdef CRITICAL_WORD_FIRST_EN
                    chk("wr_flags", {62'b0, write_tag_array, crit},
                        {62'b0, we.tag, we.crit});
`else
                    chk("wr_tag", {63'b0, write_tag_array},
                        {63'b0, we.tag});
`endif
                end
            end else begin
                chk("nowr", {14'b0, write_tag_array, crit, fill_addr,
                             fill_data, 16'h0}, 64'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int e, strays;
        rst_n         = 1'b0;
        miss_detected = 1'b1;
        miss_address  = 16'h1234;
        #1;
        outs_zero("reset_outs");
        step;
        step;
        outs_zero("reset_outs_miss");
        miss_detected = 1'b0;
        rst_n         = 1'b1;
        step;
        outs_zero("idle_outs");

        // basic fill
        start_fill(16'h1234, 1'b0, e);
        at_cycle(e);
        chk("c1_addr", {63'b0, mem_en, mem_addr}, {47'b0, 1'b1, 16'h1230});
        at_cycle(e + 4);
        chk("c5_wr", {47'b0, write_data_array, fill_addr, fill_data},
            {47'b0, 1'b1, 16'h1230, 16'hA000});
        at_cycle(e + 11);
        chk("c12_tag", {47'b0, write_tag_array, fill_addr, fill_data},
            {47'b0, 1'b1, 16'h123E, 16'hA007});
        wait_idle;

        // miss during fill is ignored
        start_fill(16'h1234, 1'b0, e);
        while (cyc < e + 5) step;
        miss_address  = 16'h5678;
        miss_detected = 1'b1;
        step;
        miss_detected = 1'b0;
        at_cycle(e + 12);
        chk("c13_idle", {63'b0, fsm_busy}, 64'h0);
        wait_idle;

        // back-to-back: miss held, address switched in cycle 12
        start_fill(16'h1234, 1'b1, e);
        while (cyc < e + 11) step;
        miss_address = 16'h2000;
        expect_fill(16'h2000, e + 13);
        while (cyc < e + 13) step;
        miss_detected = 1'b0;
        #3;
        chk("b2b_addr", {63'b0, mem_en, mem_addr}, {47'b0, 1'b1, 16'h2000});
        wait_idle;

        // reset in cycle 7 of a fill
        start_fill(16'h1234, 1'b0, e);
        while (cyc < e + 6) step;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        iss_q.delete();
        wr_q.delete();
        for (int i = 6; i < 12; i++) exp_busy[e + i] = 1'b0;
        #1;
        outs_zero("rst_mid_outs");
        @(negedge clk);
        #1;
        rst_n  = 1'b1;
        strays = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (memory_data_valid) begin
                strays++;
                chk("stray_ignored", {63'b0, write_data_array}, 64'h0);
            end
        end
        chk("strays_seen", {32'b0, strays}, 64'd2);
        step;
        wait_idle;

        // wrap at the top of the address space
        start_fill(16'hFFFE, 1'b0, e);
        at_cycle(e + 11);
        chk("wrap_tag", {63'b0, write_tag_array}, 64'h1);
        wait_idle;

        // critical word 0x123A
        start_fill(16'h123A, 1'b0, e);
        at_cycle(e);
`ifdef CRITICAL_WORD_FIRST_EN
        chk("cwf_c1", {48'b0, mem_addr}, 64'h123A);
        at_cycle(e + 4);
        chk("cwf_crit", {47'b0, crit, fill_addr}, {47'b0, 1'b1, 16'h123A});
        at_cycle(e + 11);
        chk("cwf_tag", {47'b0, write_tag_array, fill_addr},
            {47'b0, 1'b1, 16'h1238});
`else
        chk("ord_c1", {48'b0, mem_addr}, 64'h1230);
        at_cycle(e + 11);
        chk("ord_tag", {47'b0, write_tag_array, fill_addr},
            {47'b0, 1'b1, 16'h123E});
`endif
        wait_idle;
        step;
        step;
        chk("iss_q_empty", {32'b0, iss_q.size()}, 64'h0);
        chk("wr_q_empty", {32'b0, wr_q.size()}, 64'h0);
        outs_zero("final_idle");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss handler that sits directly upstream of memory4c, the multi-cycle memory (single-cycle write, 4-cycle pipelined read).
- On a cache miss it fetches one 16-byte block as 8 pipelined 16-bit reads and streams the returned words into the cache data array.
- It writes the tag array with the last word, and asserts fsm_busy throughout so the pipeline stalls.

Parameters:
- ADDR_WIDTH, 16, byte-address width; must match memory4c.
- WORDS_PER_BLOCK, 8, 16-bit words per block; power of two; block = 2*WORDS_PER_BLOCK bytes.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- miss_detected  in  1  level; cache miss pending
- miss_address  in  ADDR_WIDTH  byte address of the missing access
- memory_data  in  16  read data from memory4c
- memory_data_valid  in  1  read data valid from memory4c
- fsm_busy  out  1  fill in progress; stall request
- mem_en  out  1  memory enable
- mem_wr  out  1  memory write; constant 0
- mem_addr  out  ADDR_WIDTH  memory read address, always even
- write_data_array  out  1  cache data-array write strobe
- write_tag_array  out  1  cache tag-array write strobe
- fill_addr  out  ADDR_WIDTH  address of the word being written to the cache
- fill_data  out  16  data written to the cache; equals memory_data

Behaviour:
- States: IDLE, FILL. Registers:
  - state
  - base, the block address = miss_address with its low log2(2*WORDS_PER_BLOCK) bits zeroed
  - issue_cnt and recv_cnt, each log2(WORDS_PER_BLOCK)+1 bits
- Reset (async, rst_n=0) forces state=IDLE and clears all counters and base. All outputs are 0 while in reset and in IDLE.
- IDLE:
  - fsm_busy=0. memory_data_valid is ignored.
  - miss_detected=1 at an edge latches base, clears both counters, and moves to FILL.
- FILL, issue side:
  - fsm_busy=1.
  - While issue_cnt<WORDS_PER_BLOCK: mem_en=1, mem_addr = base + 2*word(issue_cnt), and issue_cnt increments each cycle.
  - After all words are issued: mem_en=0, mem_addr=0.
  - One request per cycle, no gaps.
- FILL, receive side:
  - When memory_data_valid=1: write_data_array=1 (combinational), fill_addr = base + 2*word(recv_cnt), fill_data=memory_data, and recv_cnt increments.
- Completion:
  - The valid that brings recv_cnt to WORDS_PER_BLOCK also asserts write_tag_array=1 in the same cycle, with fill_addr still the last word's address.
  - Next state is IDLE.
- Default word order: word(i)=i.
- Timing, miss sampled at edge 0:
  - Issues occur in cycles 1..8.
  - Data returns in cycles 5..12 (memory latency 4).
  - Tag write occurs in cycle 12; fsm_busy is high for cycles 1..12.
  - Total 12 busy cycles.
- Boundaries:
  - miss_detected while in FILL is ignored; miss_address changes during FILL are ignored, since base is latched.
  - The cache must deassert miss_detected in the cycle after write_tag_array. If it is still high, a new fill starts; this is legal.
  - Address arithmetic is modulo 2^ADDR_WIDTH; a block at 0xFFF0 fills 0xFFF0..0xFFFE.
  - Valids arriving after recv_cnt is full cannot occur in FILL. Stray valids from a memory read pipeline flushed by reset arrive in IDLE and are ignored.
  - Reset mid-FILL aborts the fill with no tag write. Partial data-array writes already made are left in place; the tag stays invalid.
  - mem_wr is never 1; the fill never writes memory.

Optional Feature:
- CRITICAL_WORD_FIRST_EN
- Defined:
  - Latch start = miss_address word offset (bits [3:1] for 8 words).
  - word(i) = (start+i) mod WORDS_PER_BLOCK for both issue and receive.
  - Add output crit_valid (1 bit): pulses with the first write_data_array of a fill, so the stalled load can proceed early. Reset value 0.
- Undefined: word(i)=i; the crit_valid port is absent.

Test Plan:
- Basic fill: miss_address=0x1234 pulsed one cycle, memory4c model preloaded mem[0x1230+2k]=0xA000+k.
  - mem_addr=0x1230,0x1232,…,0x123E in cycles 1..8.
  - write_data_array in cycles 5..12 with fill_addr/fill_data 0x1230/0xA000 … 0x123E/0xA007.
  - write_tag_array only in cycle 12; fsm_busy 1..12.
- Miss during fill: during a fill of 0x1234, miss_address=0x5678 with miss_detected=1 in cycle 6.
  - No change: still 8 issues to 0x123x, no 0x567x access.
  - Busy drops in cycle 13.
- Back-to-back misses: miss_detected held through cycle 12, then address switched to 0x2000 in cycle 12.
  - A second fill starts, with mem_addr=0x2000 in cycle 14.
- Reset mid-fill: rst_n=0 asynchronously in cycle 7 of a fill.
  - All outputs go 0 immediately; no write_tag_array.
  - Stray memory_data_valid pulses after reset release cause no write_data_array.
- Wrap: miss_address=0xFFFE.
  - Addresses 0xFFF0..0xFFFE; fill completes normally.
- CRITICAL_WORD_FIRST_EN: miss_address=0x123A.
  - Issue order 0x123A,0x123C,0x123E,0x1230,…,0x1238.
  - crit_valid pulses in cycle 5 with fill_addr=0x123A.
  - Tag write in cycle 12 with fill_addr=0x1238.
